cntr8_ns_ctrl: RTL
==================

// Module: cntr8_ns_ctrl
// PURPOSE
//  Upstream control stage of the 8-bit load/up/down counter. Registers the 3-bit counter state from
//  load/inc/dec commands and drives it to the counter output-logic stage, which maps each state to
//  d_out: IDLE->0, LOAD->d_in, INC/INC2->d_out+1, DEC/DEC2->d_out-1.
//  Alternates INC<->INC2 and DEC<->DEC2 on consecutive cycles so the state changes on every step.
//  Keeps a registered mirror of the expected count (cnt_mirror) and flags illegal command combinations.
// PARAMETERS
//  WIDTH       8       width of d_in and cnt_mirror
//  IDLE_STATE  3'b000  state encoding; must match output logic
//  LOAD_STATE  3'b001
//  INC_STATE   3'b010
//  INC2_STATE  3'b011
//  DEC_STATE   3'b100
//  DEC2_STATE  3'b101
// PORTS
//  clk         in   1      single clock; all flops on rising edge
//  reset       in   1      synchronous, active-high reset
//  load        in   1      load command: next count = d_in
//  inc         in   1      increment command
//  dec         in   1      decrement command
//  d_in        in   WIDTH  load value; sampled on the same edge as load
//  state       out  3      registered counter state; feeds output-logic state input
//  cnt_mirror  out  WIDTH  registered expected count (value output logic presents for state)
//  cmd_err     out  1      registered 1-cycle pulse: more than one command asserted on that edge
// BEHAVIOUR
//  - Reset: on a rising edge with reset=1, state=IDLE_STATE, cnt_mirror=0, cmd_err=0, overriding
//    all commands. Reset mid-sequence, e.g. in INC2, gives IDLE on that edge. No asynchronous path.
//  - Latency: commands sampled at edge k; state and cnt_mirror reflect them after edge k (1 cycle).
//  - Command priority: load > inc > dec. Lower-priority commands are ignored when higher is set.
//  - Next state, evaluated every cycle:
//    * load=1                      -> LOAD (from any state, incl. LOAD itself)
//    * else inc=1: INC->INC2, INC2->INC, any other state -> INC
//    * else dec=1: DEC->DEC2, DEC2->DEC, any other state -> DEC
//    * else no command             -> hold current state
//    * illegal state 3'b110/3'b111 -> IDLE on next edge regardless of commands; cnt_mirror=0
//  - cnt_mirror update, same edge as the state update:
//    * ->LOAD: cnt_mirror<=d_in
//    * INC step: +1 modulo 2^WIDTH, 8'hFF->8'h00
//    * DEC step: -1 modulo 2^WIDTH, 8'h00->8'hFF
//    * hold or IDLE: unchanged (IDLE after reset/illegal: 0)
//    * repeated load: reloads d_in each cycle
//  - cmd_err<=1 for one cycle when two or more of load/inc/dec are high on an edge. Command still
//    executes by priority. Not sticky.
//  - No combinational input-to-output paths. All outputs are registered.
// TESTING
//  1 reset=1 for 2 cycles with load=1,d_in=8'h55 -> state=000, cnt_mirror=00, cmd_err=0
//  2 load=1,d_in=8'hFE for 1 cycle, then inc=1 for 3 cycles -> state 001,010,011,010;
//    cnt_mirror FE,FF,00,01 (wrap)
//  3 load d_in=8'h01, then dec=1 for 3 cycles -> state 001,100,101,100; cnt_mirror 01,00,FF,FE
//  4 load=1,inc=1,dec=1,d_in=8'h3C together -> state=001, cnt_mirror=3C, cmd_err pulses 1 cycle
//  5 inc for 2 cycles, idle 2 cycles, inc again -> state 010,011,011,011,010; cnt_mirror increments
//    only on inc cycles
//  6 force state=3'b111 (hierarchical), inc=1 -> next edge state=000, cnt_mirror=00;
//    reset asserted during DEC2 -> IDLE next edge

Source files
------------

// File: rtl/cntr8_ns_ctrl.sv
// Control stage for the 8-bit load/up/down counter: registers the counter state,
// a mirror of the expected count, and a one-cycle flag for overlapping commands.
module cntr8_ns_ctrl #(
  parameter int         WIDTH      = 8,
  parameter logic [2:0] IDLE_STATE = 3'b000,
  parameter logic [2:0] LOAD_STATE = 3'b001,
  parameter logic [2:0] INC_STATE  = 3'b010,
  parameter logic [2:0] INC2_STATE = 3'b011,
  parameter logic [2:0] DEC_STATE  = 3'b100,
  parameter logic [2:0] DEC2_STATE = 3'b101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] d_in,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] cnt_mirror,
  output logic             cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE = IDLE_STATE,
    S_LOAD = LOAD_STATE,
    S_INC  = INC_STATE,
    S_INC2 = INC2_STATE,
    S_DEC  = DEC_STATE,
    S_DEC2 = DEC2_STATE
  } state_e;

  // Kept as plain bits so an out-of-range encoding can be held and recovered from.
  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_mirror_q, cnt_mirror_d;
  logic             cmd_err_q, cmd_err_d;
  logic             state_legal;

  always_comb begin
    state_legal = 1'b1;
    case (state_q)
      S_IDLE, S_LOAD, S_INC, S_INC2, S_DEC, S_DEC2: state_legal = 1'b1;
      default:                                      state_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_mirror_d = cnt_mirror_q;
    cmd_err_d    = (load & inc) | (load & dec) | (inc & dec);
    if (!state_legal) begin
      state_d      = S_IDLE;
      cnt_mirror_d = '0;
    end else if (load) begin
      state_d      = S_LOAD;
      cnt_mirror_d = d_in;
    end else if (inc) begin
      state_d      = (state_q == S_INC) ? S_INC2 : S_INC;
      cnt_mirror_d = cnt_mirror_q + WIDTH'(1);
    end else if (dec) begin
      state_d      = (state_q == S_DEC) ? S_DEC2 : S_DEC;
      cnt_mirror_d = cnt_mirror_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_mirror_q <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_mirror_q <= cnt_mirror_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign state      = state_q;
  assign cnt_mirror = cnt_mirror_q;
  assign cmd_err    = cmd_err_q;

endmodule
